// File: rtl/ooo_dump_pkg.sv
// -----------------------------------------------------------------------------
// ooo_dump_pkg
// Shared types and constants for the architectural state dump block:
//   dump_tag_t   - record type carried on dump_tag_out
//   dump_state_t - dump FSM states
//   WORD_BYTES   - bytes per data-segment word
//   word_count() - ceil(size/WORD_BYTES) saturated at a cap
// -----------------------------------------------------------------------------
package ooo_dump_pkg;

   localparam int WORD_BYTES = 8;

   typedef enum logic [1:0] {
      TAG_REG  = 2'd0,
      TAG_PC   = 2'd1,
      TAG_NZCV = 2'd2,
      TAG_MEM  = 2'd3
   } dump_tag_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REGS     = 3'd1,
      ST_PC       = 3'd2,
      ST_NZCV     = 3'd3,
      ST_MEM_REQ  = 3'd4,
      ST_MEM_WAIT = 3'd5,
      ST_MEM_OUT  = 3'd6,
      ST_FIN      = 3'd7
   } dump_state_t;

   // Number of whole or partial words covering size_bytes, clamped to max_words.
   // Dividing first keeps the rounding free of overflow near 2^64.
   function automatic logic [63:0] word_count(input logic [63:0] size_bytes,
                                              input logic [63:0] max_words);
      logic [63:0] w;
      w = size_bytes / 64'(WORD_BYTES);
      if ((size_bytes % 64'(WORD_BYTES)) != 64'd0) begin
         w = w + 64'd1;
      end
      return (w > max_words) ? max_words : w;
   endfunction

endpackage

// File: rtl/dump_edge_detect.sv
// -----------------------------------------------------------------------------
// dump_edge_detect
// Rising-edge detector for the core completion level. The previous-value
// register resets to 0, so a level that is already high when reset releases
// counts as a rising edge.
// Ports:
//   clk_in    - clock
//   rst_in_N  - asynchronous active-low reset
//   sig_in    - level to watch
//   rise_out  - high in the cycle where sig_in=1 and the registered value is 0
// -----------------------------------------------------------------------------
module dump_edge_detect (
   input  logic clk_in,
   input  logic rst_in_N,
   input  logic sig_in,
   output logic rise_out
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = sig_in;
   end

   always_ff @(posedge clk_in or negedge rst_in_N) begin
      if (!rst_in_N) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise_out = sig_in & ~prev_q;

endmodule

// File: rtl/ooo_state_dump.sv
// -----------------------------------------------------------------------------
// ooo_state_dump
// After the out-of-order core raises done, snapshots architectural state and
// drains it as a valid/ready record stream: R0..R(NUM_REGS-1), PC, NZCV and,
// when built with DUMP_MEM_EN, the data segment read word by word.
//
// Build option: define DUMP_MEM_EN to include the data-segment read path and
// MEM states. Without it the memory port is tied off and the dump ends at NZCV.
//
// Ports:
//   clk_in, rst_in_N        - clock, asynchronous active-low reset
//   done_in                 - core completion level (rising edge starts a dump)
//   reg_file_in             - R0..R(NUM_REGS-1), R[j] at bits [64*j +: 64]
//   pc_in, nzcv_in          - program counter, condition flags
//   data_start_addr_in      - data-segment base byte address
//   data_size_in            - data-segment size in bytes
//   mem_rd_en_out/addr_out  - one-cycle read strobe, 8-byte aligned address
//   mem_rd_data_in          - read data, valid one cycle after the strobe
//   dump_valid_out/ready_in - record handshake
//   dump_tag_out            - 0 REG, 1 PC, 2 NZCV, 3 MEM
//   dump_idx_out            - register number or memory word index
//   dump_data_out           - payload (NZCV zero-extended in [3:0])
//   dump_last_out           - final record of the dump
//   busy_out                - dump in progress
//   dump_done_out           - one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module ooo_state_dump
   import ooo_dump_pkg::*;
#(
   parameter int NUM_REGS      = 32,
   parameter int MAX_MEM_WORDS = 4096,
   parameter int IDX_WIDTH     = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in_N,
   input  logic                     done_in,
   input  logic [64*NUM_REGS-1:0]   reg_file_in,
   input  logic [63:0]              pc_in,
   input  logic [3:0]               nzcv_in,
   input  logic [63:0]              data_start_addr_in,
   input  logic [63:0]              data_size_in,
   output logic                     mem_rd_en_out,
   output logic [63:0]              mem_rd_addr_out,
   input  logic [63:0]              mem_rd_data_in,
   output logic                     dump_valid_out,
   input  logic                     dump_ready_in,
   output logic [1:0]               dump_tag_out,
   output logic [IDX_WIDTH-1:0]     dump_idx_out,
   output logic [63:0]              dump_data_out,
   output logic                     dump_last_out,
   output logic                     busy_out,
   output logic                     dump_done_out
);

   // ------------------------------------------------------------------------
   // Trigger detection
   // ------------------------------------------------------------------------
   logic done_rise;

   dump_edge_detect u_edge (
      .clk_in   (clk_in),
      .rst_in_N (rst_in_N),
      .sig_in   (done_in),
      .rise_out (done_rise)
   );

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   dump_state_t            state_q, state_d;
   logic                   valid_q, valid_d;
   dump_tag_t              tag_q, tag_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [63:0]            data_q, data_d;
   logic                   last_q, last_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // Registers R1..R(NUM_REGS-1) are held in a shift chain: each accepted
   // register record pulls the next one from entry 0. R0 goes straight from
   // the input into the output register on the trigger cycle.
   logic [63:0]            snap_q [0:NUM_REGS-2];
   logic [63:0]            snap_d [0:NUM_REGS-2];
   logic [63:0]            pc_snap_q, pc_snap_d;
   logic [3:0]             nzcv_snap_q, nzcv_snap_d;

`ifdef DUMP_MEM_EN
   logic [63:0]            base_q, base_d;
   logic [63:0]            words_q, words_d;
   logic [63:0]            mem_idx_q, mem_idx_d;
`else
   logic                   unused_mem_inputs;
   assign unused_mem_inputs = ^{mem_rd_data_in, data_start_addr_in, data_size_in};
`endif

   logic xfer;
   assign xfer = valid_q & dump_ready_in;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      idx_d       = idx_q;
      data_d      = data_q;
      last_d      = last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      snap_d      = snap_q;
      pc_snap_d   = pc_snap_q;
      nzcv_snap_d = nzcv_snap_q;
`ifdef DUMP_MEM_EN
      base_d      = base_q;
      words_d     = words_q;
      mem_idx_d   = mem_idx_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (done_rise) begin
               for (int k = 0; k < NUM_REGS - 1; k++) begin
                  snap_d[k] = reg_file_in[64*(k+1) +: 64];
               end
               pc_snap_d   = pc_in;
               nzcv_snap_d = nzcv_in;
`ifdef DUMP_MEM_EN
               base_d      = data_start_addr_in;
               words_d     = word_count(data_size_in, 64'(MAX_MEM_WORDS));
               mem_idx_d   = 64'd0;
`endif
               state_d = ST_REGS;
               valid_d = 1'b1;
               tag_d   = TAG_REG;
               idx_d   = '0;
               data_d  = reg_file_in[63:0];
               last_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         ST_REGS: begin
            if (xfer) begin
               if (idx_q == IDX_WIDTH'(NUM_REGS - 1)) begin
                  state_d = ST_PC;
                  tag_d   = TAG_PC;
                  idx_d   = '0;
                  data_d  = pc_snap_q;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  data_d = snap_q[0];
                  for (int k = 0; k < NUM_REGS - 2; k++) begin
                     snap_d[k] = snap_q[k+1];
                  end
               end
            end
         end

         ST_PC: begin
            if (xfer) begin
               state_d = ST_NZCV;
               tag_d   = TAG_NZCV;
               idx_d   = '0;
               data_d  = {60'd0, nzcv_snap_q};
`ifdef DUMP_MEM_EN
               last_d  = (words_q == 64'd0);
`else
               last_d  = 1'b1;
`endif
            end
         end

         ST_NZCV: begin
            if (xfer) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
`ifdef DUMP_MEM_EN
               if (words_q != 64'd0) begin
                  state_d = ST_MEM_REQ;
               end else begin
                  state_d = ST_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
`else
               state_d = ST_FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end
         end

`ifdef DUMP_MEM_EN
         // The strobe is decoded from this state, so it lasts exactly one cycle.
         ST_MEM_REQ: begin
            state_d = ST_MEM_WAIT;
         end

         ST_MEM_WAIT: begin
            state_d = ST_MEM_OUT;
            valid_d = 1'b1;
            tag_d   = TAG_MEM;
            idx_d   = mem_idx_q[IDX_WIDTH-1:0];
            data_d  = mem_rd_data_in;
            last_d  = ((mem_idx_q + 64'd1) == words_q);
         end

         ST_MEM_OUT: begin
            if (xfer) begin
               valid_d   = 1'b0;
               last_d    = 1'b0;
               mem_idx_d = mem_idx_q + 64'd1;
               if (last_q) begin
                  state_d = ST_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_MEM_REQ;
               end
            end
         end
`endif

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_in_N) begin
      if (!rst_in_N) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         tag_q   <= TAG_REG;
         idx_q   <= '0;
         data_q  <= 64'd0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Snapshot storage is only read after a trigger has loaded it.
   always_ff @(posedge clk_in) begin
      snap_q      <= snap_d;
      pc_snap_q   <= pc_snap_d;
      nzcv_snap_q <= nzcv_snap_d;
`ifdef DUMP_MEM_EN
      base_q      <= base_d;
      words_q     <= words_d;
      mem_idx_q   <= mem_idx_d;
`endif
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
`ifdef DUMP_MEM_EN
   assign mem_rd_en_out   = (state_q == ST_MEM_REQ);
   // 64-bit add wraps naturally; address is held at 0 outside the strobe.
   assign mem_rd_addr_out = mem_rd_en_out ? (base_q + (mem_idx_q * 64'(WORD_BYTES))) : 64'd0;
`else
   assign mem_rd_en_out   = 1'b0;
   assign mem_rd_addr_out = 64'd0;
`endif

   assign dump_valid_out = valid_q;
   assign dump_tag_out   = tag_q;
   assign dump_idx_out   = idx_q;
   assign dump_data_out  = data_q;
   assign dump_last_out  = last_q;
   assign busy_out       = busy_q;
   assign dump_done_out  = done_q;

endmodule
